// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer feeding a combinational instruction ROM.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module fetch_unit #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic [7:0]        BranchOffset,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              CallEn,
  input  logic              RetEn,
  input  logic              HaltIn,
  output logic [ADDR_W-1:0] InstAddress,
  output logic              FetchValid,
  output logic              Done,
  output logic [15:0]       InstCount,
  output logic              RasErr
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_HALT  = 2'd2;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_pc_br;
  logic [15:0]       r_cnt;
  logic              w_start_load, w_cnt_inc;

  // Natural ADDR_W-bit wrap gives the modulo-2^ADDR_W PC arithmetic.
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  assign w_pc_br      = r_pc + {{(ADDR_W-8){BranchOffset[7]}}, BranchOffset};
  assign w_start_load = (r_state != S_RUN) && Start;

`ifdef FETCH_RAS_EN
  localparam int              SP_W    = $clog2(RAS_DEPTH + 1);
  localparam int              IDX_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] r_ras;
  logic [SP_W-1:0]                  r_sp;
  logic                             r_ras_err;
  logic                             w_push, w_pop, w_ras_err_set;
  logic [IDX_W-1:0]                 w_top_idx, w_push_idx;

  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_push_idx = IDX_W'(r_sp);
`else
  logic w_unused_ras;
  assign w_unused_ras = CallEn ^ RetEn;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_inc   = 1'b0;
`ifdef FETCH_RAS_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_ras_err_set = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = StartAddr;
        end
      end
      S_RUN: begin
        if (HaltIn) begin
          w_state_nxt = S_HALT;
        end else if (!Stall) begin
          w_cnt_inc = 1'b1;
          w_pc_nxt  = w_pc_inc;
`ifdef FETCH_RAS_EN
          // Underflow falls through to PC+1; overflow still takes the call.
          if (RetEn) begin
            if (r_sp != '0) begin
              w_pc_nxt = r_ras[w_top_idx];
              w_pop    = 1'b1;
            end else begin
              w_ras_err_set = 1'b1;
            end
          end else if (CallEn) begin
            w_pc_nxt = JumpTarget;
            if (r_sp != SP_FULL) w_push = 1'b1;
            else                 w_ras_err_set = 1'b1;
          end else
`endif
          if (JumpEn)        w_pc_nxt = JumpTarget;
          else if (BranchEn) w_pc_nxt = w_pc_br;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_pc    <= START_ADDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_start_load)                     r_cnt <= '0;
      else if (w_cnt_inc && r_cnt != CNT_MAX) r_cnt <= r_cnt + 16'd1;
    end
  end

`ifdef FETCH_RAS_EN
  // A fresh Start begins with an empty stack as well as a clear error flag.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_ras     <= '0;
      r_sp      <= '0;
      r_ras_err <= 1'b0;
    end else if (w_start_load) begin
      r_sp      <= '0;
      r_ras_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_ras[w_push_idx] <= w_pc_inc;
        r_sp              <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_ras_err_set) r_ras_err <= 1'b1;
    end
  end

  assign RasErr = r_ras_err;
`else
  assign RasErr = 1'b0;
`endif

  assign InstAddress = r_pc;
  assign FetchValid  = (r_state == S_RUN);
  assign Done        = (r_state == S_HALT);
  assign InstCount   = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch addresses are queued as
// stimulus is applied and popped when the following clock edge has settled.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       ResetN, Start, Stall, BranchEn, JumpEn, CallEn, RetEn, HaltIn;
  logic [9:0] StartAddr, JumpTarget;
  logic [7:0] BranchOffset;
  logic [9:0] InstAddress;
  logic       FetchValid, Done, RasErr;
  logic [15:0] InstCount;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  fetch_unit dut (
    .CLK(CLK), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .BranchEn(BranchEn), .BranchOffset(BranchOffset),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget), .CallEn(CallEn), .RetEn(RetEn),
    .HaltIn(HaltIn), .InstAddress(InstAddress), .FetchValid(FetchValid),
    .Done(Done), .InstCount(InstCount), .RasErr(RasErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_in();
    Start = 0; Stall = 0; BranchEn = 0; JumpEn = 0; CallEn = 0; RetEn = 0;
    HaltIn = 0; StartAddr = '0; JumpTarget = '0; BranchOffset = '0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Advance one clock and hand back the oldest queued expected address.
  task automatic step_pop(output logic [9:0] exp_addr);
    tick();
    exp_addr = exp_q.pop_front();
  endtask

  // Reset pulse then Start at addr; leaves DUT in RUN at addr.
  task automatic restart(input logic [9:0] addr);
    clr_in();
    ResetN = 0; #3; ResetN = 1;
    Start = 1; StartAddr = addr;
    tick();
    clr_in();
  endtask

  task automatic test_reset();
    clr_in();
    ResetN = 0;
    #12;
    n_tests++; if (InstAddress !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", InstAddress); end
    n_tests++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", FetchValid); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_tests++; if (InstCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", InstCount); end
    n_tests++; if (RasErr !== 1'b0) begin n_fail++; $display("FAIL reset_raserr: got %b want 0", RasErr); end
    ResetN = 1;
    // IDLE ignores redirects
    JumpEn = 1; JumpTarget = 10'h155;
    exp_q.push_back(10'h000); step_pop(e);
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL idle_hold: got %h want %h", InstAddress, e); end
    clr_in();
  endtask

  task automatic test_sequential();
    Start = 1; StartAddr = 10'h010;
    exp_q.push_back(10'h010); step_pop(e);
    Start = 0;
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL start_addr: got %h want %h", InstAddress, e); end
    n_tests++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL start_valid: got %b want 1", FetchValid); end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(10'h010 + 10'(i)); step_pop(e);
      n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, InstAddress, e); end
    end
    n_tests++; if (InstCount !== 16'd3) begin n_fail++; $display("FAIL seq_count: got %0d want 3", InstCount); end
    n_tests++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b want 1", FetchValid); end
  endtask

  task automatic test_branch();
    logic [9:0] tgt [5] = '{10'h005, 10'h000, 10'h3FF, 10'h000, 10'h001};
    restart(10'h005);
    // {branch_en, offset, jump_en, target, expected}
    BranchEn = 1; BranchOffset = 8'hFD;
    exp_q.push_back(10'h002); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL br_neg: got %h want %h", InstAddress, e); end
    JumpEn = 1; JumpTarget = tgt[2];
    exp_q.push_back(10'h3FF); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL jmp_3ff: got %h want %h", InstAddress, e); end
    exp_q.push_back(10'h000); step_pop(e);
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL wrap_inc: got %h want %h", InstAddress, e); end
    JumpEn = 1; JumpTarget = 10'h3FF;
    exp_q.push_back(10'h3FF); step_pop(e); clr_in();
    BranchEn = 1; BranchOffset = 8'h02;
    exp_q.push_back(10'h001); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL br_wrap_pos: got %h want %h", InstAddress, e); end
    BranchEn = 1; BranchOffset = 8'hFD;
    exp_q.push_back(10'h3FE); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL br_wrap_neg: got %h want %h", InstAddress, e); end
    BranchEn = 1; BranchOffset = 8'h80;
    exp_q.push_back(10'h37E); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL br_min: got %h want %h", InstAddress, e); end
  endtask

  task automatic test_priority();
    restart(10'h050);
    JumpEn = 1; BranchEn = 1; JumpTarget = 10'h100; BranchOffset = 8'h10;
    exp_q.push_back(10'h100); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL jmp_over_br: got %h want %h", InstAddress, e); end
    n_tests++; if (InstCount !== 16'd1) begin n_fail++; $display("FAIL pri_count: got %0d want 1", InstCount); end
    Stall = 1; JumpEn = 1; JumpTarget = 10'h222;
    exp_q.push_back(10'h100); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL stall_hold: got %h want %h", InstAddress, e); end
    n_tests++; if (InstCount !== 16'd1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", InstCount); end
  endtask

  task automatic test_halt();
    restart(10'h01F);
    exp_q.push_back(10'h020); step_pop(e);
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL pre_halt: got %h want %h", InstAddress, e); end
    HaltIn = 1; Stall = 1; JumpEn = 1; JumpTarget = 10'h300;
    exp_q.push_back(10'h020); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL halt_addr: got %h want %h", InstAddress, e); end
    n_tests++; if (Done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b want 1", Done); end
    n_tests++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b want 0", FetchValid); end
    n_tests++; if (InstCount !== 16'd1) begin n_fail++; $display("FAIL halt_count: got %0d want 1", InstCount); end
    JumpEn = 1; JumpTarget = 10'h3AA; BranchEn = 1; BranchOffset = 8'h05;
    exp_q.push_back(10'h020); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL halt_ignore: got %h want %h", InstAddress, e); end
    Start = 1; StartAddr = 10'h000;
    exp_q.push_back(10'h000); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL restart_addr: got %h want %h", InstAddress, e); end
    n_tests++; if (FetchValid !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL restart_state: valid=%b done=%b want 1/0", FetchValid, Done); end
    n_tests++; if (InstCount !== 16'd0) begin n_fail++; $display("FAIL restart_count: got %0d want 0", InstCount); end
    // Start while running is ignored
    Start = 1; StartAddr = 10'h2AA;
    exp_q.push_back(10'h001); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL start_in_run: got %h want %h", InstAddress, e); end
  endtask

  task automatic test_async_reset();
    restart(10'h040);
    JumpEn = 1; JumpTarget = 10'h044;
    exp_q.push_back(10'h044); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL pre_rst: got %h want %h", InstAddress, e); end
    #2 ResetN = 0;
    #1;
    n_tests++; if (InstAddress !== 10'h000) begin n_fail++; $display("FAIL async_addr: got %h want 000", InstAddress); end
    n_tests++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", FetchValid); end
    n_tests++; if (InstCount !== 16'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", InstCount); end
    tick();
    ResetN = 1;
    tick();
    exp_q.push_back(10'h000); step_pop(e);
    n_tests++; if (InstAddress !== e || FetchValid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %h/%b want %h/0", InstAddress, FetchValid, e); end
    Start = 1; StartAddr = 10'h050;
    exp_q.push_back(10'h050); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e || FetchValid !== 1'b1) begin n_fail++; $display("FAIL resume: got %h/%b want %h/1", InstAddress, FetchValid, e); end
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras();
    restart(10'h030);
    CallEn = 1; JumpTarget = 10'h200;
    exp_q.push_back(10'h200); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL call: got %h want %h", InstAddress, e); end
    RetEn = 1;
    exp_q.push_back(10'h031); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL ret: got %h want %h", InstAddress, e); end
    n_tests++; if (RasErr !== 1'b0) begin n_fail++; $display("FAIL ret_err: got %b want 0", RasErr); end
    RetEn = 1;
    exp_q.push_back(10'h032); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL underflow_addr: got %h want %h", InstAddress, e); end
    n_tests++; if (RasErr !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", RasErr); end
    restart(10'h040);
    n_tests++; if (RasErr !== 1'b0) begin n_fail++; $display("FAIL reset_clears_err: got %b want 0", RasErr); end
    for (int i = 0; i < 5; i++) begin
      CallEn = 1; JumpTarget = 10'h100 + 10'(i);
      exp_q.push_back(10'h100 + 10'(i)); step_pop(e); clr_in();
      n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL nest_call%0d: got %h want %h", i, InstAddress, e); end
      n_tests++; if (RasErr !== (i == 4)) begin n_fail++; $display("FAIL nest_err%0d: got %b want %b", i, RasErr, (i == 4)); end
    end
    RetEn = 1;
    exp_q.push_back(10'h103); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL nest_ret: got %h want %h", InstAddress, e); end
  endtask
`else
  task automatic test_ras();
    restart(10'h030);
    CallEn = 1; JumpTarget = 10'h200;
    exp_q.push_back(10'h031); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL call_ignored: got %h want %h", InstAddress, e); end
    RetEn = 1;
    exp_q.push_back(10'h032); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL ret_ignored: got %h want %h", InstAddress, e); end
    n_tests++; if (RasErr !== 1'b0) begin n_fail++; $display("FAIL raserr_tied: got %b want 0", RasErr); end
    CallEn = 1; JumpEn = 1; JumpTarget = 10'h123;
    exp_q.push_back(10'h123); step_pop(e); clr_in();
    n_tests++; if (InstAddress !== e) begin n_fail++; $display("FAIL call_falls_to_jump: got %h want %h", InstAddress, e); end
  endtask
`endif

  initial begin
    clr_in();
    ResetN = 1;
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_halt();
    test_async_reset();
    test_ras();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
